// File: rtl/uart_sys_pkg.sv
// ----------------------------------------------------------------------------
// uart_sys_pkg
// Shared definitions for the UART system controller: sequencer state
// encoding, error-cause codes reported on err_code and the default frame
// opcodes.
// ----------------------------------------------------------------------------
package uart_sys_pkg;

   // Command sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StWrExec,
      StRdAddr,
      StRdReq,
      StRdWait,
      StTxSend
   } state_t;

   // Error causes reported on err_code alongside the err pulse
   localparam logic [1:0] ERR_OVERRUN = 2'd0;
   localparam logic [1:0] ERR_OPCODE  = 2'd1;
   localparam logic [1:0] ERR_ADDR    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Default frame opcodes
   localparam logic [7:0] WR_CMD = 8'hAA;
   localparam logic [7:0] RD_CMD = 8'hBB;

endpackage : uart_sys_pkg

// File: rtl/uart_sys_ctrl.sv
// ----------------------------------------------------------------------------
// uart_sys_ctrl
// Command sequencer between UART_RX, a register file and UART_TX. Byte frames
// from the receiver are parsed into register writes (opcode, addr, data) and
// register reads (opcode, addr). Read data is handed to the transmitter with
// a valid/busy handshake. All outputs are registered.
//
// Ports
//   CLK              system clock
//   RST              asynchronous active-low reset
//   RX_P_DATA        received byte
//   RX_D_VLD         single-cycle strobe qualifying RX_P_DATA
//   RF_WrEn          register-file write strobe (one cycle per write frame)
//   RF_RdEn          register-file read strobe (one cycle per read frame)
//   RF_Address       register-file address, held between frames
//   RF_WrData        register-file write data, held between frames
//   RF_RdData        register-file read data
//   RF_RdData_Valid  strobe qualifying RF_RdData
//   TX_P_DATA        byte to transmit, stable while TX_D_VLD is high
//   TX_D_VLD         transmit request, accepted when TX_BUSY is low
//   TX_BUSY          transmitter busy
//   err              single-cycle error pulse
//   err_code         error cause, valid with err, holds otherwise
// ----------------------------------------------------------------------------
module uart_sys_ctrl #(
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       ADDR_W     = 4,
   parameter logic [DATA_W-1:0] WR_CMD     = uart_sys_pkg::WR_CMD,
   parameter logic [DATA_W-1:0] RD_CMD     = uart_sys_pkg::RD_CMD,
   parameter int unsigned       RD_TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] RX_P_DATA,
   input  logic              RX_D_VLD,
   output logic              RF_WrEn,
   output logic              RF_RdEn,
   output logic [ADDR_W-1:0] RF_Address,
   output logic [DATA_W-1:0] RF_WrData,
   input  logic [DATA_W-1:0] RF_RdData,
   input  logic              RF_RdData_Valid,
   output logic [DATA_W-1:0] TX_P_DATA,
   output logic              TX_D_VLD,
   input  logic              TX_BUSY,
   output logic              err,
   output logic [1:0]        err_code
);

   import uart_sys_pkg::*;

   localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
   // The counter holds the number of cycles elapsed since RF_RdEn; the wait
   // gives up on the cycle whose increment reaches RD_TIMEOUT, so err lands
   // exactly RD_TIMEOUT cycles after the read strobe.
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              wr_en_q, rd_en_q, tx_vld_q;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic              addr_ok;
   logic              busy_state;
   logic              timed_out;

   // Upper address bits beyond the register-file depth must be zero
   assign addr_ok   = (RX_P_DATA[DATA_W-1:ADDR_W] == '0);
   assign timed_out = (cnt_q >= CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tx_data_d  = tx_data_q;
      err_d      = 1'b0;
      code_d     = code_q;
      busy_state = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == WR_CMD) begin
                  state_d = StWrAddr;
               end else if (RX_P_DATA == RD_CMD) begin
                  state_d = StRdAddr;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_OPCODE;
               end
            end
         end

         StWrAddr, StRdAddr: begin
            if (RX_D_VLD) begin
               if (!addr_ok) begin
                  err_d   = 1'b1;
                  code_d  = ERR_ADDR;
                  state_d = StIdle;
               end else begin
                  addr_d  = RX_P_DATA[ADDR_W-1:0];
                  state_d = (state_q == StWrAddr) ? StWrData : StRdReq;
                  cnt_d   = '0;
               end
            end
         end

         StWrData: begin
            if (RX_D_VLD) begin
               wdata_d = RX_P_DATA;
               state_d = StWrExec;
            end
         end

         StWrExec: begin
            busy_state = 1'b1;
            state_d    = StIdle;
         end

         StRdReq: begin
            busy_state = 1'b1;
            cnt_d      = CNT_W'(1);
            state_d    = StRdWait;
         end

         StRdWait: begin
            busy_state = 1'b1;
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            // Valid data wins over a simultaneous timeout
            if (RF_RdData_Valid) begin
               tx_data_d = RF_RdData;
               state_d   = StTxSend;
            end else if (timed_out) begin
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               state_d = StIdle;
            end
         end

         StTxSend: begin
            busy_state = 1'b1;
            if (!TX_BUSY) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      // Bytes arriving while a command executes are dropped; a timeout
      // reported in the same cycle keeps its code.
      if (RX_D_VLD && busy_state && !err_d) begin
         err_d  = 1'b1;
         code_d = ERR_OVERRUN;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_vld_q  <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_data_q <= tx_data_d;
         // Strobes are registered from the next state so they coincide with
         // the cycle spent in the corresponding state.
         wr_en_q   <= (state_d == StWrExec);
         rd_en_q   <= (state_d == StRdReq);
         tx_vld_q  <= (state_d == StTxSend);
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign RF_WrEn    = wr_en_q;
   assign RF_RdEn    = rd_en_q;
   assign RF_Address = addr_q;
   assign RF_WrData  = wdata_q;
   assign TX_P_DATA  = tx_data_q;
   assign TX_D_VLD   = tx_vld_q;
   assign err        = err_q;
   assign err_code   = code_q;

endmodule : uart_sys_ctrl

// File: tb/tb_uart_sys_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_sys_ctrl
// Self-checking bench for uart_sys_ctrl: a per-cycle vector table covers
// write frames, opcode/address errors, back-to-back frames and overrun in
// WR_EXEC; hand-written sequences cover reads, TX back-pressure, overrun
// during a read, read timeout and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_uart_sys_ctrl;

   logic       CLK;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       RF_WrEn;
   logic       RF_RdEn;
   logic [3:0] RF_Address;
   logic [7:0] RF_WrData;
   logic [7:0] RF_RdData;
   logic       RF_RdData_Valid;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_BUSY;
   logic       err;
   logic [1:0] err_code;

   int errors = 0;
   int checks = 0;

   // Activity monitors, sampled on the falling edge
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         tx_acc = 0;
   logic [3:0] last_wr_addr = '0;
   logic [7:0] last_wr_data = '0;

   uart_sys_ctrl #(
      .DATA_W     (8),
      .ADDR_W     (4),
      .WR_CMD     (8'hAA),
      .RD_CMD     (8'hBB),
      .RD_TIMEOUT (16)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .RX_P_DATA       (RX_P_DATA),
      .RX_D_VLD        (RX_D_VLD),
      .RF_WrEn         (RF_WrEn),
      .RF_RdEn         (RF_RdEn),
      .RF_Address      (RF_Address),
      .RF_WrData       (RF_WrData),
      .RF_RdData       (RF_RdData),
      .RF_RdData_Valid (RF_RdData_Valid),
      .TX_P_DATA       (TX_P_DATA),
      .TX_D_VLD        (TX_D_VLD),
      .TX_BUSY         (TX_BUSY),
      .err             (err),
      .err_code        (err_code)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK) begin
      if (RST) begin
         if (RF_WrEn) begin
            wr_cnt++;
            last_wr_addr = RF_Address;
            last_wr_data = RF_WrData;
         end
         if (RF_RdEn) rd_cnt++;
         if (TX_D_VLD && !TX_BUSY) tx_acc++;
      end
   end

   typedef struct {
      logic       vld;
      logic [7:0] b;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wd;
      logic       e;
      logic [1:0] code;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic vld, input logic [7:0] b, input logic wr,
                               input logic [3:0] addr, input logic [7:0] wd,
                               input logic e, input logic [1:0] code);
      vec_t v;
      v.vld  = vld;
      v.b    = b;
      v.wr   = wr;
      v.addr = addr;
      v.wd   = wd;
      v.e    = e;
      v.code = code;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      RX_D_VLD  = 1'b1;
      RX_P_DATA = b;
      tick();
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h00;
   endtask

   int base_tx, base_rd, base_wr, n_vld;
   logic early, stable, redo, dropped;

   initial begin
      RST             = 1'b0;
      RX_P_DATA       = 8'h00;
      RX_D_VLD        = 1'b0;
      RF_RdData       = 8'h00;
      RF_RdData_Valid = 1'b0;
      TX_BUSY         = 1'b0;

      //            vld  byte   wr  addr   wd     err code
      vecs[0]  = mk(1, 8'hAA, 0, 4'h0, 8'h00, 0, 2'd0);
      vecs[1]  = mk(1, 8'h05, 0, 4'h5, 8'h00, 0, 2'd0);
      vecs[2]  = mk(1, 8'h3C, 1, 4'h5, 8'h3C, 0, 2'd0);
      vecs[3]  = mk(0, 8'h00, 0, 4'h5, 8'h3C, 0, 2'd0);
      vecs[4]  = mk(1, 8'h7E, 0, 4'h5, 8'h3C, 1, 2'd1);  // bad opcode
      vecs[5]  = mk(0, 8'h00, 0, 4'h5, 8'h3C, 0, 2'd1);  // code holds
      vecs[6]  = mk(1, 8'hBB, 0, 4'h5, 8'h3C, 0, 2'd1);
      vecs[7]  = mk(1, 8'h15, 0, 4'h5, 8'h3C, 1, 2'd2);  // bad address
      vecs[8]  = mk(0, 8'h00, 0, 4'h5, 8'h3C, 0, 2'd2);
      vecs[9]  = mk(1, 8'hAA, 0, 4'h5, 8'h3C, 0, 2'd2);
      vecs[10] = mk(1, 8'h01, 0, 4'h1, 8'h3C, 0, 2'd2);
      vecs[11] = mk(1, 8'hFF, 1, 4'h1, 8'hFF, 0, 2'd2);
      vecs[12] = mk(0, 8'h00, 0, 4'h1, 8'hFF, 0, 2'd2);
      vecs[13] = mk(1, 8'hAA, 0, 4'h1, 8'hFF, 0, 2'd2);  // back-to-back opcode
      vecs[14] = mk(1, 8'h07, 0, 4'h7, 8'hFF, 0, 2'd2);
      vecs[15] = mk(1, 8'hAA, 1, 4'h7, 8'hAA, 0, 2'd2);  // data byte not decoded
      vecs[16] = mk(1, 8'h22, 0, 4'h7, 8'hAA, 1, 2'd0);  // overrun in WR_EXEC
      vecs[17] = mk(0, 8'h00, 0, 4'h7, 8'hAA, 0, 2'd0);

      // Reset state
      #12;
      chk("rst wr", RF_WrEn, 0);
      chk("rst rd", RF_RdEn, 0);
      chk("rst addr", RF_Address, 0);
      chk("rst wdata", RF_WrData, 0);
      chk("rst txv", TX_D_VLD, 0);
      chk("rst txdata", TX_P_DATA, 0);
      chk("rst err", err, 0);
      chk("rst code", err_code, 0);
      RST = 1'b1;
      tick();

      // Vector table
      for (int i = 0; i < 18; i++) begin
         RX_D_VLD  = vecs[i].vld;
         RX_P_DATA = vecs[i].b;
         tick();
         chk($sformatf("v%0d wr", i), RF_WrEn, vecs[i].wr);
         chk($sformatf("v%0d rd", i), RF_RdEn, 0);
         chk($sformatf("v%0d addr", i), RF_Address, vecs[i].addr);
         chk($sformatf("v%0d wdata", i), RF_WrData, vecs[i].wd);
         chk($sformatf("v%0d err", i), err, vecs[i].e);
         chk($sformatf("v%0d code", i), err_code, vecs[i].code);
         chk($sformatf("v%0d txv", i), TX_D_VLD, 0);
      end
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h00;
      tick();

      // Basic read: valid two cycles after RF_RdEn, transmitter idle
      base_tx = tx_acc;
      base_rd = rd_cnt;
      send(8'hBB);
      send(8'h05);
      chk("rd rden", RF_RdEn, 1);
      chk("rd addr", RF_Address, 5);
      tick();
      chk("rd rden drop", RF_RdEn, 0);
      tick();
      RF_RdData_Valid = 1'b1;
      RF_RdData       = 8'h3C;
      tick();
      RF_RdData_Valid = 1'b0;
      RF_RdData       = 8'h00;
      chk("rd txv", TX_D_VLD, 1);
      chk("rd txdata", TX_P_DATA, 8'h3C);
      tick();
      chk("rd txv drop", TX_D_VLD, 0);
      chk("rd accepts", tx_acc - base_tx, 1);
      chk("rd strobes", rd_cnt - base_rd, 1);

      // Read with transmitter busy for 20 cycles of TX_SEND
      base_tx = tx_acc;
      TX_BUSY = 1'b1;
      send(8'hBB);
      send(8'h05);
      tick();
      RF_RdData_Valid = 1'b1;
      RF_RdData       = 8'h3C;
      tick();
      RF_RdData_Valid = 1'b0;
      RF_RdData       = 8'h00;
      n_vld   = 0;
      stable  = 1'b1;
      redo    = 1'b0;
      dropped = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (TX_D_VLD) begin
            if (dropped) redo = 1'b1;
            n_vld++;
            if (TX_P_DATA !== 8'h3C) stable = 1'b0;
            if (n_vld == 21) TX_BUSY = 1'b0;
         end else if (n_vld > 0) begin
            dropped = 1'b1;
         end
         tick();
      end
      TX_BUSY = 1'b0;
      chk("busy txv cycles", n_vld, 21);
      chk("busy data stable", stable, 1);
      chk("busy single request", redo, 0);
      chk("busy accepts", tx_acc - base_tx, 1);

      // Overrun during RD_WAIT: byte dropped, read completes
      base_tx = tx_acc;
      send(8'hBB);
      send(8'h05);
      tick();
      RX_D_VLD  = 1'b1;
      RX_P_DATA = 8'h55;
      tick();
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h00;
      chk("ovr err", err, 1);
      chk("ovr code", err_code, 0);
      RF_RdData_Valid = 1'b1;
      RF_RdData       = 8'h9A;
      tick();
      RF_RdData_Valid = 1'b0;
      RF_RdData       = 8'h00;
      chk("ovr err drop", err, 0);
      chk("ovr txv", TX_D_VLD, 1);
      chk("ovr txdata", TX_P_DATA, 8'h9A);
      tick();
      chk("ovr txv drop", TX_D_VLD, 0);
      chk("ovr accepts", tx_acc - base_tx, 1);

      // Timeout: no read data
      send(8'hBB);
      send(8'h02);
      chk("tmo rden", RF_RdEn, 1);
      early = 1'b0;
      for (int k = 1; k < 16; k++) begin
         tick();
         if (err) early = 1'b1;
      end
      chk("tmo no early err", early, 0);
      tick();
      chk("tmo err", err, 1);
      chk("tmo code", err_code, 3);
      chk("tmo txv", TX_D_VLD, 0);
      tick();
      chk("tmo err drop", err, 0);
      chk("tmo code hold", err_code, 3);

      // Reset mid-frame after AA,05 then a fresh write to address 1
      base_wr = wr_cnt;
      send(8'hAA);
      send(8'h05);
      RST = 1'b0;
      #3;
      chk("mid rst wr", RF_WrEn, 0);
      chk("mid rst addr", RF_Address, 0);
      chk("mid rst code", err_code, 0);
      chk("mid rst txv", TX_D_VLD, 0);
      #3;
      RST = 1'b1;
      tick();
      tick();
      chk("post rst no write", wr_cnt - base_wr, 0);
      send(8'hAA);
      send(8'h01);
      send(8'hFF);
      chk("post rst wr", RF_WrEn, 1);
      chk("post rst addr", RF_Address, 1);
      chk("post rst wdata", RF_WrData, 8'hFF);
      tick();
      tick();
      chk("post rst write count", wr_cnt - base_wr, 1);
      chk("post rst write addr", last_wr_addr, 1);
      chk("post rst write data", last_wr_data, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_sys_ctrl
